// File: rtl/reg_scoreboard.sv
// Per-register scoreboard for the in-order RV64 ID stage: tracks in-flight destinations
// with a forwardability countdown and a pending-writer count, and makes the stall/issue call.
module reg_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int LAT_W          = 3,
    parameter int PEND_W         = 2,
    parameter int PERF_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic                      id_rs1_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_rd_we,
    input  logic [LAT_W-1:0]          id_lat,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      stall,
    output logic                      issue,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic [PERF_W-1:0]         stall_cycles
);

    logic [LAT_W-1:0]  cnt  [NUM_REGS];
    logic [PEND_W-1:0] pend [NUM_REGS];

    logic [LAT_W-1:0]    eff_lat;
    logic                raw_rs1;
    logic                raw_rs2;
    logic                waw;
    logic                do_wr;
    logic                wb_ok;
    logic [NUM_REGS-1:0] iss_hit;
    logic [NUM_REGS-1:0] wb_hit;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Hazard detection and issue decision are purely combinational on current state.
    always_comb begin
        eff_lat = (id_lat == '0) ? LAT_W'(1) : id_lat;
        raw_rs1 = id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0);
        raw_rs2 = id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0);
        waw     = id_rd_we && (id_rd != '0) &&
                  ((cnt[id_rd] >= eff_lat) || (pend[id_rd] == '1));
        stall   = id_valid && !flush && (raw_rs1 || raw_rs2 || waw);
        issue   = id_valid && !flush && !hold && !stall;
        do_wr   = issue && id_rd_we && (id_rd != '0);
        wb_ok   = wb_valid && (wb_rd != '0) && (pend[wb_rd] != '0);
    end

    always_comb begin
        iss_hit  = '0;
        wb_hit   = '0;
        busy_vec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            iss_hit[i]  = do_wr && (id_rd == REG_ADDR_WIDTH'(i));
            wb_hit[i]   = wb_ok && (wb_rd == REG_ADDR_WIDTH'(i));
            busy_vec[i] = (pend[i] != '0);
        end
    end

    // Register 0 is never written after reset, so it can never look busy or hazardous.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i]  <= '0;
                pend[i] <= '0;
            end
            stall_cycles <= '0;
        end else begin
            if (!hold) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (iss_hit[i]) begin
                        cnt[i] <= eff_lat - LAT_W'(1);
                    end else if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - LAT_W'(1);
                    end
                end
                if (stall) begin
                    stall_cycles <= sat_inc(stall_cycles);
                end
            end
            // Writeback is older than any backend stall, so it retires even under hold.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (iss_hit[i] && !wb_hit[i]) begin
                    pend[i] <= pend[i] + PEND_W'(1);
                end else if (wb_hit[i] && !iss_hit[i]) begin
                    pend[i] <= pend[i] - PEND_W'(1);
                end
            end
        end
    end

    a_wb_pending: assert property (@(posedge clk) disable iff (rst)
        (wb_valid && (wb_rd != '0)) |-> (pend[wb_rd] != '0));

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a ready-time/pending-count model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_reg_scoreboard;

    localparam int NR = 32;
    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [2:0]  id_lat;
    logic        hold, flush, wb_valid;
    logic        stall, issue;
    logic [31:0] busy_vec;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat(id_lat),
        .hold(hold), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stall(stall), .issue(issue), .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t_m counts un-held cycles; a register is forwardable once t_m reaches ready_m.
    int t_m;
    int ready_m [NR];
    int pend_m  [NR];
    int sc_m;
    bit started = 0;

    function automatic int eff();
        return (id_lat == 3'd0) ? 1 : int'(id_lat);
    endfunction

    function automatic bit m_stall();
        bit h;
        h = (id_rs1_used && id_rs1 != 0 && ready_m[id_rs1] > t_m) ||
            (id_rs2_used && id_rs2 != 0 && ready_m[id_rs2] > t_m) ||
            (id_rd_we && id_rd != 0 &&
             ((ready_m[id_rd] - t_m) >= eff() || pend_m[id_rd] >= PMAX));
        return id_valid && !flush && h;
    endfunction

    function automatic bit m_issue();
        return id_valid && !flush && !hold && !m_stall();
    endfunction

    always @(posedge clk) begin : model
        bit ms, mi, inc, dec;
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                ready_m[i] = 0;
                pend_m[i]  = 0;
            end
            t_m = 0;
            sc_m = 0;
            started = 1;
        end else if (started) begin
            ms  = m_stall();
            mi  = m_issue();
            inc = mi && id_rd_we && id_rd != 0;
            dec = wb_valid && wb_rd != 0 && pend_m[wb_rd] > 0;
            if (!hold) begin
                if (ms && sc_m < 65535) sc_m = sc_m + 1;
                if (inc) ready_m[id_rd] = t_m + eff();
                t_m = t_m + 1;
            end
            if (inc && !(dec && wb_rd == id_rd)) pend_m[id_rd] = pend_m[id_rd] + 1;
            if (dec && !(inc && wb_rd == id_rd)) pend_m[wb_rd] = pend_m[wb_rd] - 1;
        end
    end

    always @(negedge clk) begin : cmp
        logic [31:0] eb;
        if (started) begin
            eb = '0;
            for (int i = 0; i < NR; i++) eb[i] = (pend_m[i] > 0);
            chk("m_stall", 32'(stall), 32'(m_stall()));
            chk("m_issue", 32'(issue), 32'(m_issue()));
            chk("m_busy", busy_vec, eb);
            chk("m_stall_cycles", 32'(stall_cycles), 32'(sc_m));
        end
    end

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_we = 0; id_lat = 0; hold = 0; flush = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic instr(input logic [4:0] rd, input logic we, input logic [2:0] lat,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        id_valid = 1; id_rd = rd; id_rd_we = we; id_lat = lat;
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        rst = 1;
        id_valid = 1;
        tick();
        rst = 0;
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_issue", 32'(issue), 1);
        chk("rst_busy", busy_vec, 0);
        chk("rst_sc", 32'(stall_cycles), 0);
        tick();

        // load x5 then dependent add x6,x5,x1: one bubble
        instr(5, 1, 2, 0, 0, 0, 0);
        #1 chk("ld_issue", 32'(issue), 1);
        tick();
        instr(6, 1, 1, 5, 1, 1, 1);
        #1 chk("ld_use_stall", 32'(stall), 1);
        chk("ld_use_noissue", 32'(issue), 0);
        tick();
        #1 chk("ld_use_stall_end", 32'(stall), 0);
        chk("ld_use_issue", 32'(issue), 1);
        chk("ld_use_sc", 32'(stall_cycles), 1);
        tick();
        idle();
        #1 chk("busy5", 32'(busy_vec[5]), 1);
        chk("busy6", 32'(busy_vec[6]), 1);
        wb_valid = 1; wb_rd = 5;
        tick();
        wb_rd = 6;
        #1 chk("busy5_clr", 32'(busy_vec[5]), 0);
        tick();
        idle();
        #1 chk("busy6_clr", 32'(busy_vec[6]), 0);

        // ALU back-to-back, and x0 never hazardous
        instr(7, 1, 1, 0, 0, 0, 0);
        tick();
        instr(0, 0, 1, 7, 1, 0, 0);
        #1 chk("alu_nostall", 32'(stall), 0);
        chk("alu_issue", 32'(issue), 1);
        tick();
        instr(0, 1, 5, 0, 0, 0, 0);
        tick();
        instr(0, 0, 1, 0, 1, 0, 1);
        #1 chk("x0_nostall", 32'(stall), 0);
        chk("x0_notbusy", 32'(busy_vec[0]), 0);
        tick();
        idle(); wb_valid = 1; wb_rd = 7;
        tick();
        idle();

        // WAW: mul x8 (lat 5) then addi x8 (lat 1) stalls 4 cycles
        instr(8, 1, 5, 0, 0, 0, 0);
        tick();
        instr(8, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1 chk("waw_stall", 32'(stall), 1);
            tick();
        end
        #1 chk("waw_issue", 32'(issue), 1);
        chk("waw_sc", 32'(stall_cycles), 5);
        tick();
        wb_valid = 1; wb_rd = 8;
        #1 chk("wb_iss_same_issue", 32'(issue), 1);
        tick();
        idle();
        #1 chk("wb_iss_same_busy", 32'(busy_vec[8]), 1);
        wb_valid = 1; wb_rd = 8;
        tick();
        #1 chk("x8_busy_one_left", 32'(busy_vec[8]), 1);
        tick();
        idle();
        #1 chk("x8_clr", 32'(busy_vec[8]), 0);

        // load x9, consumer waits through 3 hold cycles
        instr(9, 1, 2, 0, 0, 0, 0);
        tick();
        instr(0, 0, 1, 9, 1, 0, 0);
        hold = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_stall", 32'(stall), 1);
            chk("hold_noissue", 32'(issue), 0);
            tick();
        end
        #1 chk("hold_sc_frozen", 32'(stall_cycles), 5);
        hold = 0;
        #1 chk("post_hold_stall", 32'(stall), 1);
        tick();
        #1 chk("post_hold_issue", 32'(issue), 1);
        chk("post_hold_sc", 32'(stall_cycles), 6);
        tick();
        idle(); wb_valid = 1; wb_rd = 9;
        tick();
        idle();

        // pending-writer counter saturation forces a WAW stall
        instr(14, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick();
        wb_valid = 1; wb_rd = 14;
        #1 chk("pend_max_stall", 32'(stall), 1);
        tick();
        wb_valid = 0;
        #1 chk("pend_max_issue", 32'(issue), 1);
        tick();
        idle(); wb_valid = 1; wb_rd = 14;
        for (int k = 0; k < 3; k++) tick();
        idle();
        #1 chk("all_clear", busy_vec, 0);
        chk("sc_seven", 32'(stall_cycles), 7);

        // flush of a hazardous instruction, then reset with three pending registers
        instr(11, 1, 3, 0, 0, 0, 0);
        tick();
        instr(0, 0, 1, 11, 1, 0, 0);
        flush = 1;
        #1 chk("flush_stall", 32'(stall), 0);
        chk("flush_issue", 32'(issue), 0);
        tick();
        idle(); instr(12, 1, 4, 0, 0, 0, 0);
        tick();
        idle(); instr(13, 1, 4, 0, 0, 0, 0);
        tick();
        idle();
        #1 chk("three_busy", busy_vec, 32'h0000_3800);
        instr(0, 0, 1, 12, 1, 0, 0);
        #1 chk("pre_rst_stall", 32'(stall), 1);
        rst = 1;
        tick();
        rst = 0;
        #1 chk("post_rst_busy", busy_vec, 0);
        chk("post_rst_stall", 32'(stall), 0);
        chk("post_rst_sc", 32'(stall_cycles), 0);
        tick();
        tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
